// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared encodings for the shift sequencer and SHIFTER16
package shift_pkg;

  localparam int SHIFT_WIDTH = 16;

  typedef enum logic [1:0] {
    LSL = 2'b00,
    LSR = 2'b01,
    ASR = 2'b10,
    ROR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    SEL_PASS = 2'd0,
    SEL_SHR  = 2'd1,
    SEL_SHL  = 2'd2,
    SEL_ZERO = 2'd3
  } sel_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/shift_seq16_if.sv
// rtl/shift_seq16_if.sv - request/result bundle between the ALU path and the shift sequencer
interface shift_seq16_if;
  import shift_pkg::*;

  logic                   Start;
  logic [1:0]             Op;
  logic [3:0]             Amount;
  logic [SHIFT_WIDTH-1:0] A;
  logic                   Busy;
  logic                   Done;
  logic [SHIFT_WIDTH-1:0] Result;
  logic                   CarryOut;

  modport master (
    output Start, Op, Amount, A,
    input  Busy, Done, Result, CarryOut
  );

  modport slave (
    input  Start, Op, Amount, A,
    output Busy, Done, Result, CarryOut
  );

endinterface

// File: rtl/shift_seq16_shifter16.sv
// rtl/shift_seq16_shifter16.sv - existing single-bit 16-bit shifter datapath
module SHIFTER16
  import shift_pkg::*;
(
  input  logic [15:0] B,
  input  logic [1:0]  Select,
  input  logic        InL,
  input  logic        InR,
  output logic [15:0] HOut
);

  // one-bit shift, fill bits supplied by the caller
  always_comb begin
    HOut = B;
    unique case (sel_e'(Select))
      SEL_PASS: HOut = B;
      SEL_SHR:  HOut = {InL, B[15:1]};
      SEL_SHL:  HOut = {B[14:0], InR};
      SEL_ZERO: HOut = 16'h0000;
      default:  HOut = B;
    endcase
  end

endmodule

// File: rtl/shift_seq16.sv
// rtl/shift_seq16.sv - multi-cycle 0..15 bit shift/rotate sequencer around SHIFTER16
module shift_seq16
  import shift_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic          CLK,
  input  logic          RST,
  shift_seq16_if.slave  bus
);

  state_e           state;
  state_e           state_nxt;
  op_e              op_q;
  logic [3:0]       cnt;
  logic [WIDTH-1:0] hold;
  logic             carry;
  logic             accept;
  logic [1:0]       sel;
  logic             in_l;
  logic             in_r;
  logic [15:0]      hout;

  assign accept = (state == S_IDLE) && bus.Start;

  // state register; reset aborts any operation in flight
  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // next state: zero-amount requests skip straight to DONE
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (bus.Start) state_nxt = (bus.Amount == 4'd0) ? S_DONE : S_SHIFT;
      end
      S_SHIFT: begin
        if (cnt == 4'd1) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // status outputs come from state only, never from Start
  always_comb begin
    bus.Busy = (state != S_IDLE);
    bus.Done = (state == S_DONE);
  end

  // fill-bit mux: pick direction and incoming bit from the latched op
  always_comb begin
    sel  = SEL_SHR;
    in_l = 1'b0;
    in_r = 1'b0;
    unique case (op_q)
      LSL:     sel  = SEL_SHL;
      LSR:     in_l = 1'b0;
      ASR:     in_l = hold[15];
      ROR:     in_l = hold[0];
      default: in_l = 1'b0;
    endcase
  end

  SHIFTER16 u_shifter (
    .B      (hold),
    .Select (sel),
    .InL    (in_l),
    .InR    (in_r),
    .HOut   (hout)
  );

  // holding register, latched op/count and carry; the bit leaving the
  // register on each step becomes the carry
  always_ff @(posedge CLK) begin
    if (RST) begin
      hold  <= '0;
      op_q  <= LSL;
      cnt   <= 4'd0;
      carry <= 1'b0;
    end else begin
      if (accept) begin
        hold  <= bus.A;
        op_q  <= op_e'(bus.Op);
        cnt   <= bus.Amount;
        carry <= 1'b0;
      end else if (state == S_SHIFT) begin
        hold  <= hout;
        cnt   <= cnt - 4'd1;
        carry <= (op_q == LSL) ? hold[15] : hold[0];
      end
    end
  end

  assign bus.Result   = hold;
  assign bus.CarryOut = carry;

endmodule

// File: tb/tb_shift_seq16.sv
// tb/tb_shift_seq16.sv - directed vector bench for shift_seq16
module tb_shift_seq16;

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  amt;
    logic [15:0] a;
    logic [15:0] res;
    logic        cy;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  shift_seq16_if bus ();

  shift_seq16 dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 40 && bus.Busy !== 1'b0; i++) @(negedge clk);
    if (i == 40) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [3:0] amt, input logic [15:0] a,
                        input logic [15:0] er, input logic ec, input string tag);
    int  lat;
    int  busy_n;
    bit  seen;
    lat = 0; busy_n = 0; seen = 0;
    wait_idle();
    bus.Op = op; bus.Amount = amt; bus.A = a; bus.Start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.Start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      lat++;
      if (bus.Busy) busy_n++;
      if (bus.Done) begin
        seen = 1;
        break;
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, lat, 32'(amt) + 1);
    check({tag, "_busy_cycles"}, busy_n, 32'(amt) + 1);
    check({tag, "_result"}, bus.Result, er);
    check({tag, "_carry"}, bus.CarryOut, ec);
    @(negedge clk);
    @(negedge clk);
    check({tag, "_result_held"}, bus.Result, er);
    check({tag, "_no_extra_done"}, bus.Done, 1'b0);
  endtask

  vec_t vecs [10];

  initial begin
    int dcount;
    int d0;
    int d1;
    logic [15:0] res_at_done;

    vecs[0] = '{2'b00, 4'd4,  16'h0001, 16'h0010, 1'b0};
    vecs[1] = '{2'b10, 4'd15, 16'h8000, 16'hFFFF, 1'b0};
    vecs[2] = '{2'b01, 4'd8,  16'hFFFF, 16'h00FF, 1'b1};
    vecs[3] = '{2'b11, 4'd1,  16'h0001, 16'h8000, 1'b1};
    vecs[4] = '{2'b11, 4'd4,  16'h1234, 16'h4123, 1'b0};
    vecs[5] = '{2'b00, 4'd0,  16'hBEEF, 16'hBEEF, 1'b0};
    vecs[6] = '{2'b00, 4'd1,  16'h8001, 16'h0002, 1'b1};
    vecs[7] = '{2'b10, 4'd2,  16'h4000, 16'h1000, 1'b0};
    vecs[8] = '{2'b01, 4'd15, 16'h0003, 16'h0000, 1'b0};
    vecs[9] = '{2'b11, 4'd15, 16'h8001, 16'h0003, 1'b0};

    bus.Start = 1'b0; bus.Op = 2'b00; bus.Amount = 4'd0; bus.A = 16'h0000;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_busy", bus.Busy, 1'b0);
    check("reset_done", bus.Done, 1'b0);
    check("reset_result", bus.Result, 16'h0000);
    check("reset_carry", bus.CarryOut, 1'b0);

    for (int v = 0; v < 10; v++)
      run_op(vecs[v].op, vecs[v].amt, vecs[v].a, vecs[v].res, vecs[v].cy, $sformatf("vec%0d", v));

    // Start pulsed with changed operands mid-shift must be ignored
    wait_idle();
    bus.Op = 2'b00; bus.Amount = 4'd3; bus.A = 16'h0003; bus.Start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.Start = 1'b0;
    @(negedge clk);
    bus.Start = 1'b1; bus.A = 16'hFFFF; bus.Op = 2'b11; bus.Amount = 4'd7;
    @(negedge clk);
    bus.Start = 1'b0;
    dcount = 0;
    res_at_done = 16'hxxxx;
    for (int i = 0; i < 14; i++) begin
      if (bus.Done) begin
        dcount++;
        res_at_done = bus.Result;
      end
      @(negedge clk);
    end
    check("busy_ignore_done_count", dcount, 1);
    check("busy_ignore_result", res_at_done, 16'h0018);
    check("busy_ignore_idle_after", bus.Busy, 1'b0);

    // reset on the second shift cycle aborts without Done
    wait_idle();
    bus.Op = 2'b01; bus.Amount = 4'd10; bus.A = 16'hF000; bus.Start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.Start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", bus.Busy, 1'b0);
    check("midrst_done", bus.Done, 1'b0);
    check("midrst_result", bus.Result, 16'h0000);
    check("midrst_carry", bus.CarryOut, 1'b0);
    dcount = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus.Done) dcount++;
      @(negedge clk);
    end
    check("midrst_no_done", dcount, 0);
    run_op(2'b00, 4'd2, 16'h0001, 16'h0004, 1'b0, "after_rst");

    // Start held high: back-to-back accepts every Amount+2 cycles
    wait_idle();
    bus.Op = 2'b00; bus.Amount = 4'd1; bus.A = 16'h0001; bus.Start = 1'b1;
    d0 = -1; d1 = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.Done) begin
        if (d0 < 0) d0 = i;
        else if (d1 < 0) d1 = i;
      end
    end
    bus.Start = 1'b0;
    check("held_start_two_dones", 32'((d0 >= 0) && (d1 >= 0)), 32'd1);
    check("held_start_period", d1 - d0, 3);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
